// File: rtl/wired_tl_pkg.sv
// Shared TileLink-UL definitions for the wired arbiter slice.
// Opcodes, arbiter state encoding and burst helpers.
package wired_tl_pkg;

    localparam logic [2:0] PUT_FULL_DATA    = 3'd0;
    localparam logic [2:0] PUT_PARTIAL_DATA = 3'd1;
    localparam logic [2:0] ARITHMETIC_DATA  = 3'd2;
    localparam logic [2:0] LOGICAL_DATA     = 3'd3;
    localparam logic [2:0] GET              = 3'd4;
    localparam logic [2:0] ACCESS_ACK       = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA  = 3'd1;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    function automatic logic tl_has_data(input logic [2:0] opcode);
        return opcode inside {PUT_FULL_DATA, PUT_PARTIAL_DATA,
                              ARITHMETIC_DATA, LOGICAL_DATA};
    endfunction

    function automatic logic [8:0] tl_beats(input logic [7:0] size,
                                            input int data_width);
        int lg;
        lg = $clog2(data_width / 8);
        if (int'(size) > lg)
            return 9'(1) << (int'(size) - lg);
        return 9'd1;
    endfunction

endpackage

// File: rtl/wired_tl_a_arbiter_if.sv
// Host-side and device-side TileLink-UL signal bundle for the arbiter.
// The slave modport is the arbiter's view; master is the environment's.
interface wired_tl_a_arbiter_if #(
    parameter int NUM_HOSTS         = 2,
    parameter int DATA_WIDTH        = 128,
    parameter int ADDR_WIDTH        = 32,
    parameter int HOST_SOURCE_WIDTH = 3,
    parameter int SIZE_WIDTH        = 3
);
    localparam int IDX_W  = (NUM_HOSTS > 1) ? $clog2(NUM_HOSTS) : 1;
    localparam int DEV_SW = HOST_SOURCE_WIDTH + IDX_W;
    localparam int MASK_W = DATA_WIDTH / 8;

    logic [NUM_HOSTS-1:0]                   h_a_valid_i;
    logic [NUM_HOSTS-1:0]                   h_a_ready_o;
    logic [3*NUM_HOSTS-1:0]                 h_a_opcode_i;
    logic [SIZE_WIDTH*NUM_HOSTS-1:0]        h_a_size_i;
    logic [ADDR_WIDTH*NUM_HOSTS-1:0]        h_a_address_i;
    logic [HOST_SOURCE_WIDTH*NUM_HOSTS-1:0] h_a_source_i;
    logic [MASK_W*NUM_HOSTS-1:0]            h_a_mask_i;
    logic [DATA_WIDTH*NUM_HOSTS-1:0]        h_a_data_i;

    logic                   d_a_valid_o;
    logic                   d_a_ready_i;
    logic [2:0]             d_a_opcode_o;
    logic [SIZE_WIDTH-1:0]  d_a_size_o;
    logic [ADDR_WIDTH-1:0]  d_a_address_o;
    logic [DEV_SW-1:0]      d_a_source_o;
    logic [MASK_W-1:0]      d_a_mask_o;
    logic [DATA_WIDTH-1:0]  d_a_data_o;

    logic                   d_d_valid_i;
    logic                   d_d_ready_o;
    logic [2:0]             d_d_opcode_i;
    logic [SIZE_WIDTH-1:0]  d_d_size_i;
    logic [DEV_SW-1:0]      d_d_source_i;
    logic                   d_d_error_i;
    logic [DATA_WIDTH-1:0]  d_d_data_i;

    logic [NUM_HOSTS-1:0]         h_d_valid_o;
    logic [NUM_HOSTS-1:0]         h_d_ready_i;
    logic [2:0]                   h_d_opcode_o;
    logic [SIZE_WIDTH-1:0]        h_d_size_o;
    logic [HOST_SOURCE_WIDTH-1:0] h_d_source_o;
    logic                         h_d_error_o;
    logic [DATA_WIDTH-1:0]        h_d_data_o;

    logic route_err_o;

    modport slave (
        input  h_a_valid_i, h_a_opcode_i, h_a_size_i,
        input  h_a_address_i, h_a_source_i, h_a_mask_i,
        input  h_a_data_i,
        output h_a_ready_o,
        output d_a_valid_o, d_a_opcode_o, d_a_size_o,
        output d_a_address_o, d_a_source_o, d_a_mask_o,
        output d_a_data_o,
        input  d_a_ready_i,
        input  d_d_valid_i, d_d_opcode_i, d_d_size_i,
        input  d_d_source_i, d_d_error_i, d_d_data_i,
        output d_d_ready_o,
        output h_d_valid_o, h_d_opcode_o, h_d_size_o,
        output h_d_source_o, h_d_error_o, h_d_data_o,
        input  h_d_ready_i,
        output route_err_o
    );

    modport master (
        output h_a_valid_i, h_a_opcode_i, h_a_size_i,
        output h_a_address_i, h_a_source_i, h_a_mask_i,
        output h_a_data_i,
        input  h_a_ready_o,
        input  d_a_valid_o, d_a_opcode_o, d_a_size_o,
        input  d_a_address_o, d_a_source_o, d_a_mask_o,
        input  d_a_data_o,
        output d_a_ready_i,
        output d_d_valid_i, d_d_opcode_i, d_d_size_i,
        output d_d_source_i, d_d_error_i, d_d_data_i,
        input  d_d_ready_o,
        input  h_d_valid_o, h_d_opcode_o, h_d_size_o,
        input  h_d_source_o, h_d_error_o, h_d_data_o,
        output h_d_ready_i,
        input  route_err_o
    );

endinterface

// File: rtl/wired_rr_picker.sv
// Combinational round-robin picker: first requester at or after start,
// wrapping modulo NUM.
module wired_rr_picker #(
    parameter int NUM   = 2,
    parameter int IDX_W = 1
) (
    input  logic [NUM-1:0]   req,
    input  logic [IDX_W-1:0] start,
    output logic [NUM-1:0]   grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    int j;

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        j   = 0;
        idx = '0;
        for (int off = NUM - 1; off >= 0; off--) begin
            j = int'(start) + off;
            if (j >= NUM)
                j = j - NUM;
            if (req[j])
                idx = IDX_W'(j);
        end
        any   = |req;
        grant = any ? (NUM'(1) << idx) : '0;
    end

endmodule

// File: rtl/wired_tl_a_arbiter.sv
// N-host to one-device TileLink-UL arbiter with burst lock and D demux.
// Define WIRED_TL_ARB_PERF_EN to add per-host A stall counters.
module wired_tl_a_arbiter
    import wired_tl_pkg::*;
#(
    parameter int NUM_HOSTS         = 2,
    parameter int DATA_WIDTH        = 128,
    parameter int ADDR_WIDTH        = 32,
    parameter int HOST_SOURCE_WIDTH = 3,
    parameter int SIZE_WIDTH        = 3
) (
    input logic clk,
    input logic rst,
    wired_tl_a_arbiter_if.slave bus
`ifdef WIRED_TL_ARB_PERF_EN
    ,
    output logic [32*NUM_HOSTS-1:0] stall_cnt_o
`endif
);
    localparam int IDX_W  = (NUM_HOSTS > 1) ? $clog2(NUM_HOSTS) : 1;
    localparam int DEV_SW = HOST_SOURCE_WIDTH + IDX_W;
    localparam int MASK_W = DATA_WIDTH / 8;
    localparam int SW     = SIZE_WIDTH;
    localparam int AW     = ADDR_WIDTH;
    localparam int HSW    = HOST_SOURCE_WIDTH;
    localparam int DW     = DATA_WIDTH;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [7:0]       beat_cnt_q, beat_cnt_d;
    logic             route_err_q;

    logic [NUM_HOSTS-1:0] pick_oh;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;

    logic [NUM_HOSTS-1:0] sel_oh;
    logic [IDX_W-1:0]     sel;
    logic                 a_any;
    logic                 fire;
    logic [2:0]           a_opcode;
    logic [SW-1:0]        a_size;
    logic [8:0]           beats;
    logic                 is_burst;

    logic [IDX_W-1:0]     d_idx;
    logic                 route_ok;
    logic [NUM_HOSTS-1:0] d_oh;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        return (int'(i) == NUM_HOSTS - 1) ? '0 : i + IDX_W'(1);
    endfunction

    wired_rr_picker #(
        .NUM   (NUM_HOSTS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (bus.h_a_valid_i),
        .start (rr_ptr_q),
        .grant (pick_oh),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // A locked burst pins the mux to its owner even while it idles.
    always_comb begin
        sel    = pick_idx;
        sel_oh = pick_oh;
        a_any  = pick_any;
        if (state_q == ARB_LOCKED) begin
            sel    = owner_q;
            sel_oh = NUM_HOSTS'(1) << owner_q;
            a_any  = bus.h_a_valid_i[owner_q];
        end
    end

    assign a_opcode = bus.h_a_opcode_i[int'(sel)*3 +: 3];
    assign a_size   = bus.h_a_size_i[int'(sel)*SW +: SW];
    assign beats    = tl_beats(8'(a_size), DATA_WIDTH);
    assign is_burst = tl_has_data(a_opcode) && (beats > 9'd1);

    assign bus.d_a_valid_o   = !rst && a_any;
    assign bus.h_a_ready_o   = rst ? '0 :
        (sel_oh & {NUM_HOSTS{a_any && bus.d_a_ready_i}});
    assign bus.d_a_opcode_o  = a_opcode;
    assign bus.d_a_size_o    = a_size;
    assign bus.d_a_address_o = bus.h_a_address_i[int'(sel)*AW +: AW];
    assign bus.d_a_source_o  = {sel, bus.h_a_source_i[int'(sel)*HSW +: HSW]};
    assign bus.d_a_mask_o    = bus.h_a_mask_i[int'(sel)*MASK_W +: MASK_W];
    assign bus.d_a_data_o    = bus.h_a_data_i[int'(sel)*DW +: DW];

    assign fire = bus.d_a_valid_o && bus.d_a_ready_i;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        if (fire) begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (is_burst) begin
                        state_d    = ARB_LOCKED;
                        owner_d    = sel;
                        beat_cnt_d = 8'(beats - 9'd1);
                    end else begin
                        rr_ptr_d = idx_inc(sel);
                    end
                end
                ARB_LOCKED: begin
                    beat_cnt_d = beat_cnt_q - 8'd1;
                    if (beat_cnt_q == 8'd1) begin
                        state_d  = ARB_IDLE;
                        rr_ptr_d = idx_inc(owner_q);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Unroutable responses are swallowed so the device never stalls.
    assign d_idx    = bus.d_d_source_i[DEV_SW-1 -: IDX_W];
    assign route_ok = int'(d_idx) < NUM_HOSTS;
    assign d_oh     = NUM_HOSTS'(1) << d_idx;

    assign bus.h_d_valid_o =
        (rst || !route_ok || !bus.d_d_valid_i) ? '0 : d_oh;
    assign bus.d_d_ready_o =
        rst ? 1'b0 : (route_ok ? bus.h_d_ready_i[d_idx] : 1'b1);

    assign bus.h_d_opcode_o = bus.d_d_opcode_i;
    assign bus.h_d_size_o   = bus.d_d_size_i;
    assign bus.h_d_source_o = bus.d_d_source_i[HSW-1:0];
    assign bus.h_d_error_o  = bus.d_d_error_i;
    assign bus.h_d_data_o   = bus.d_d_data_i;
    assign bus.route_err_o  = route_err_q;

    always_ff @(posedge clk) begin
        if (rst)
            route_err_q <= 1'b0;
        else if (bus.d_d_valid_i && !route_ok)
            route_err_q <= 1'b1;
    end

`ifdef WIRED_TL_ARB_PERF_EN
    for (genvar h = 0; h < NUM_HOSTS; h++) begin : g_stall
        logic [31:0] cnt;
        always_ff @(posedge clk) begin
            if (rst)
                cnt <= '0;
            else if (bus.h_a_valid_i[h] && !bus.h_a_ready_o[h]
                     && (cnt != '1))
                cnt <= cnt + 32'd1;
        end
        assign stall_cnt_o[h*32 +: 32] = cnt;
    end
`endif

endmodule

// File: doc/wired_tl_a_arbiter.md
Name: wired_tl_a_arbiter

Overview:
- Shares one TileLink-UL device port (128-bit, single device) between NUM_HOSTS host ports, e.g. I-cache and D-cache refill/writeback paths ahead of the broadcaster and width adapter.
- A channel: round-robin arbitration, grant locked for the full duration of multi-beat data bursts, host index prepended to the source.
- D channel: responses demultiplexed back to hosts by the upper source bits.

Parameters:
- NUM_HOSTS, 2, number of host ports (2..8).
- DATA_WIDTH, 128, data bits per beat.
- ADDR_WIDTH, 32, address bits.
- HOST_SOURCE_WIDTH, 3, source bits per host.
- SIZE_WIDTH, 3, log2(bytes) size field width.
- Derived: IDX_W = $clog2(NUM_HOSTS) (min 1); DEV_SOURCE_WIDTH = HOST_SOURCE_WIDTH+IDX_W.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- h_a_valid_i/h_a_ready_o  in/out  NUM_HOSTS  per-host A handshake.
- h_a_opcode_i  in  3*NUM_HOSTS  per-host A opcode.
- h_a_size_i  in  SIZE_WIDTH*NUM_HOSTS  per-host A size.
- h_a_address_i  in  ADDR_WIDTH*NUM_HOSTS  per-host A address.
- h_a_source_i  in  HOST_SOURCE_WIDTH*NUM_HOSTS  per-host A source.
- h_a_mask_i  in  DATA_WIDTH/8*NUM_HOSTS  per-host A byte mask.
- h_a_data_i  in  DATA_WIDTH*NUM_HOSTS  per-host A data.
- d_a_valid_o/d_a_ready_i  out/in  1  device A handshake.
- d_a_opcode_o, d_a_size_o, d_a_address_o, d_a_mask_o, d_a_data_o  out  as above  muxed A fields.
- d_a_source_o  out  DEV_SOURCE_WIDTH  {host index, host source}.
- d_d_valid_i/d_d_ready_o  in/out  1  device D handshake.
- d_d_opcode_i  in  3  D opcode.
- d_d_size_i  in  SIZE_WIDTH  D size.
- d_d_source_i  in  DEV_SOURCE_WIDTH  D source.
- d_d_error_i  in  1  D denied/corrupt.
- d_d_data_i  in  DATA_WIDTH  D data.
- h_d_valid_o/h_d_ready_i  out/in  NUM_HOSTS  per-host D handshake.
- h_d_opcode_o, h_d_size_o, h_d_error_o, h_d_data_o  out  1x per host  D fields broadcast to all hosts.
- h_d_source_o  out  HOST_SOURCE_WIDTH  low source bits.
- route_err_o  out  1  sticky: D response carried host index >= NUM_HOSTS.

Behaviour:
- State: rr_ptr (IDX_W), locked (1), owner (IDX_W), beat_cnt (8 bits). Reset: rr_ptr=0, locked=0, owner=0, beat_cnt=0, route_err_o=0.
- While rst=1, force d_a_valid_o=0, all h_a_ready_o=0, all h_d_valid_o=0, d_d_ready_o=0.
- A arbitration is combinational, zero-latency; A fields pass through with no register.
- IDLE (locked=0): grant = first valid host searching rr_ptr, rr_ptr+1, … modulo NUM_HOSTS. d_a_valid_o = any valid. Only the granted host sees h_a_ready_o = d_a_ready_i.
- Burst detect: opcode in {0,1,2,3} (data-carrying) and size > log2(DATA_WIDTH/8). Beats = 2^(size - log2(DATA_WIDTH/8)).
- On first-beat fire of a burst: locked=1, owner=grant, beat_cnt=beats-1.
- On single-beat fire: rr_ptr = grant+1 mod NUM_HOSTS; remain IDLE.
- LOCKED: only owner is selected; other hosts' a_ready=0 regardless of valid. Each fire decrements beat_cnt. The fire with beat_cnt==1 is the last beat: locked=0, rr_ptr=owner+1 mod NUM_HOSTS.
- Owner deasserting valid mid-burst: lock held, no other grant.
- Reset mid-burst: lock dropped immediately.
- D channel: idx = d_d_source_i[DEV_SOURCE_WIDTH-1 -: IDX_W]. h_d_valid_o[idx] = d_d_valid_i; d_d_ready_o = h_d_ready_i[idx]. Payload fields broadcast to all hosts.
- idx >= NUM_HOSTS: d_d_ready_o=1 (beat dropped), no h_d_valid, route_err_o set until reset.
- A and D are independent; simultaneous A grant and D delivery to the same host is allowed.

Optional Feature:
- WIRED_TL_ARB_PERF_EN: adds output stall_cnt_o (32*NUM_HOSTS). Per host, a 32-bit saturating counter increments each cycle with h_a_valid_i=1 && h_a_ready_o=0. Counters reset to 0.
- Without the macro: port and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package wired_tl_pkg: TL opcode localparams (PutFullData=0, PutPartialData=1, ArithmeticData=2, LogicalData=3, Get=4, AccessAck=0, AccessAckData=1), function tl_has_data(opcode), function tl_beats(size, data_width).
- Sub-module wired_rr_picker: NUM parameter; inputs req vector and start pointer; outputs one-hot grant and index; purely combinational.

Test Plan:
- Hosts 0 and 1 both hold Get (opcode 4, size 4), d_a_ready=1 -> grants alternate 0,1,0,1; d_a_source_o = {idx, src}.
- Host 0 PutFullData size 6 (4 beats) while host 1 holds Get -> host 0 holds exactly 4 consecutive fires, host 1 granted on the 5th; rr_ptr=1 after burst.
- Mid-burst: owner drops valid 3 cycles, d_a_ready toggling -> host 1 never granted until beat 4 fires.
- D response source {1,3'd5}, host 1 d_ready=0 for 2 cycles -> d_d_ready_o=0 for those cycles, h_d_valid_o=2'b10, h_d_source_o=5.
- NUM_HOSTS=3, D source index 3 -> beat consumed, route_err_o=1, stays 1 until rst.
- rst asserted during beat 2 of a burst -> next cycle locked=0, rr_ptr=0, host 1 Get granted first.
